// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: control codes, FSM states
// and the iteration counter width helper.
package alu_seq_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_iter.sv
// Iterative datapath: unsigned shift-add multiplier and restoring divider.
// One step per cycle; the controller decides when to load, step and stop.
module alu_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_mul,
    input  logic             load_div,
    input  logic             step_mul,
    input  logic             step_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] mul_res,
    output logic [WIDTH-1:0] div_res
);

    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [WIDTH-1:0] divisor, quot, rem;
    logic [WIDTH-1:0] acc_nx, quot_nx, rem_nx;
    logic [WIDTH:0]   rem_sh, trial;

    always_comb begin
        acc_nx  = mplier[0] ? acc + mcand : acc;
        // Working remainder is WIDTH+1 bits so the trial sign is visible.
        rem_sh  = {rem, quot[WIDTH-1]};
        trial   = rem_sh - {1'b0, divisor};
        rem_nx  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_nx = {quot[WIDTH-2:0], ~trial[WIDTH]};
    end

    assign mul_res = acc_nx;
    assign div_res = quot_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            divisor <= '0;
            quot    <= '0;
            rem     <= '0;
        end else if (load_mul) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
        end else if (load_div) begin
            divisor <= op_b;
            quot    <= op_a;
            rem     <= '0;
        end else if (step_mul) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else if (step_div) begin
            rem  <= rem_nx;
            quot <= quot_nx;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: accepts one operation, runs add/sub in one cycle
// and mul/div over WIDTH cycles, returns the result on a valid/ready channel.
//
// Handshakes: a request transfers on a cycle where req_valid && req_ready; a
// response transfers on a cycle where rsp_valid && rsp_ready. Each side holds
// its payload stable until the transfer happens.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t          state, state_nx;
    logic [CW-1:0]   count;
    logic            accept;
    logic            b_zero;
    logic [WIDTH-1:0] mul_res, div_res;

    assign b_zero = (op_b == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                accept    = req_valid;
                if (req_valid) begin
                    case (alu_ctrl)
                        ALU_MUL: state_nx = MUL;
                        ALU_DIV: state_nx = b_zero ? DONE : DIV;
                        default: state_nx = DONE;
                    endcase
                end
            end
            MUL:  if (count == '0) state_nx = DONE;
            DIV:  if (count == '0) state_nx = DONE;
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    div_by_zero <= 1'b0;
                    case (alu_ctrl)
                        ALU_SUB: result <= op_a - op_b;
                        ALU_MUL: count  <= CW'(WIDTH - 1);
                        ALU_DIV: begin
                            if (b_zero) begin
                                result      <= '1;
                                div_by_zero <= 1'b1;
                            end else begin
                                count <= CW'(WIDTH - 1);
                            end
                        end
                        default: result <= op_a + op_b;
                    endcase
                end
                MUL: begin
                    if (count == '0) result <= mul_res;
                    else             count  <= count - 1'b1;
                end
                DIV: begin
                    if (count == '0) result <= div_res;
                    else             count  <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load_mul (accept && (alu_ctrl == ALU_MUL)),
        .load_div (accept && (alu_ctrl == ALU_DIV) && !b_zero),
        .step_mul (state == MUL),
        .step_div (state == DIV),
        .op_a     (op_a),
        .op_b     (op_b),
        .mul_res  (mul_res),
        .div_res  (div_res)
    );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with an expected-result queue.
module tb_alu_seq_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   alu_ctrl = 3'b000;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] result;
    logic         div_by_zero;
    logic         busy;

    logic [W:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .result(result), .div_by_zero(div_by_zero),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model: {div_by_zero, result}
    function automatic logic [W:0] model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        case (c)
            3'b001:  return {1'b0, a - b};
            3'b010:  begin p = 64'(a) * 64'(b); return {1'b0, p[W-1:0]}; end
            3'b011:  return (b == 0) ? {1'b1, {W{1'b1}}} : {1'b0, a / b};
            default: return {1'b0, a + b};
        endcase
    endfunction

    task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        req_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
        exp_q.push_back(model(c, a, b));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // scramble inputs: an operation in flight must ignore them
        alu_ctrl = 3'($urandom_range(0, 7));
        op_a = $urandom;
        op_b = $urandom;
    endtask

    task automatic wait_rsp(input string tag, input int lat);
        int cycles = 0;
        bit got = 0;
        bit busy_ok = 1;
        logic [W:0] e;
        while (!got && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (rsp_valid) got = 1;
            else if (!busy || req_ready) busy_ok = 0;
        end
        chk({tag, "_latency"}, 64'(cycles), 64'(lat));
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        if (got) begin
            chk({tag, "_result"}, 64'(result), 64'(e[W-1:0]));
            chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e[W]));
            chk({tag, "_busy"}, 64'({busy, req_ready}), 64'(2'b10));
        end
        if (lat > 1) chk({tag, "_busy_thru"}, 64'(busy_ok), 64'(1));
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_idle"}, 64'({req_ready, rsp_valid, busy}), 64'(3'b100));
    endtask

    task automatic run_op(input string tag, input logic [2:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat);
        issue(c, a, b);
        wait_rsp(tag, lat);
        retire(tag);
    endtask

    initial begin
        logic [W-1:0] held;
        bit seen;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 64'({req_ready, rsp_valid, busy, div_by_zero}), 64'(4'b1000));
        chk("reset_result", 64'(result), 64'(0));
        rst = 1'b0;

        run_op("add_5_7",    3'b000, 32'd5, 32'd7, 1);
        run_op("sub_3_5",    3'b001, 32'd3, 32'd5, 1);
        run_op("mul_ffff",   3'b010, 32'h0000FFFF, 32'h0000FFFF, W + 1);
        run_op("mul_ovf",    3'b010, 32'h80000000, 32'd2, W + 1);
        run_op("div_100_7",  3'b011, 32'd100, 32'd7, W + 1);
        run_op("div_3_9",    3'b011, 32'd3, 32'd9, W + 1);
        run_op("div_ones_1", 3'b011, 32'hFFFFFFFF, 32'd1, W + 1);
        run_op("div_by_0",   3'b011, 32'd42, 32'd0, 1);
        run_op("add_after0", 3'b000, 32'd1, 32'd1, 1);
        run_op("ctrl_1xx",   3'b110, 32'd10, 32'd20, 1);

        for (int i = 0; i < 4; i++) begin
            logic [2:0] c;
            c = 3'($urandom_range(0, 3));
            run_op("rand", c, $urandom, 32'($urandom_range(1, 32'hFFFF)),
                   (c >= 3'd2) ? W + 1 : 1);
        end

        // backpressure: hold response, offer a new request meanwhile
        issue(3'b010, 32'd1234, 32'd5678);
        wait_rsp("bp_mul", W + 1);
        held = result;
        req_valid = 1'b1; alu_ctrl = 3'b000; op_a = 32'd9; op_b = 32'd1;
        exp_q.push_back(model(3'b000, 32'd9, 32'd1));
        seen = 1;
        repeat (3) begin
            @(negedge clk);
            if (!(rsp_valid && !req_ready && result == held)) seen = 0;
        end
        chk("bp_stable", 64'(seen), 64'(1));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        // retire cycle must not also accept the held request
        chk("bp_retire_idle", 64'({req_ready, rsp_valid, busy}), 64'(3'b100));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp("bp_next_add", 1);
        retire("bp_next_add");

        // reset in the middle of a divide
        issue(3'b011, 32'd1000, 32'd3);
        void'(exp_q.pop_back());
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_outs", 64'({req_ready, rsp_valid, busy, div_by_zero}), 64'(4'b1000));
        chk("abort_result", 64'(result), 64'(0));
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1;
        end
        chk("abort_no_rsp", 64'(seen), 64'(0));
        run_op("add_post_rst", 3'b000, 32'd100, 32'd23, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle operation sequencer between the control path and the ALU datapath.
- Accepts one decoded ALU operation at a time (3-bit ALU control code plus two operands).
- Completes add/sub in a single execute cycle; runs mul (shift-add) and div (restoring) iteratively over WIDTH cycles.
- Returns the result over a valid/ready response channel and drives busy so the pipeline can stall.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 4).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  operation request valid.
- req_ready  out  1  sequencer can accept a request.
- alu_ctrl  in  3  ALU control code: 000 add, 001 sub, 010 mul, 011 div, 1xx treated as add.
- op_a  in  WIDTH  first operand (minuend, multiplicand, dividend).
- op_b  in  WIDTH  second operand (subtrahend, multiplier, divisor).
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- div_by_zero  out  1  qualifies result when rsp_valid: div with op_b == 0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock; one synchronous active-high reset; all outputs registered or decoded from the state register only.
- Reset values:
  - state IDLE, count 0, result 0, div_by_zero 0.
  - rsp_valid 0, req_ready 1, busy 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - req_ready = 1.
  - Request is accepted when req_valid && req_ready (cycle N); operands and code are latched that cycle.
  - add: result <= op_a + op_b, modulo 2^WIDTH; go to DONE.
  - sub: result <= op_a - op_b, modulo 2^WIDTH, two's complement; go to DONE.
  - mul: acc <= 0, count <= WIDTH-1; go to MUL.
  - div with op_b != 0: rem <= 0, quot <= op_a, count <= WIDTH-1; go to DIV.
  - div with op_b == 0: result <= all ones, div_by_zero <= 1; go to DONE with no iteration.
- MUL, unsigned shift-add:
  - Each cycle: if mplier[0], acc += mcand; mcand <<= 1; mplier >>= 1.
  - When count == 0: result <= low WIDTH bits of the final acc; go to DONE. Otherwise count decrements.
- DIV, unsigned restoring, remainder register WIDTH+1 bits:
  - Each cycle: shift {rem, quot} left by 1, then trial-subtract the divisor.
  - If non-negative, keep the difference and set quot[0] = 1; otherwise restore.
  - When count == 0: result <= quotient (truncated toward zero), div_by_zero <= 0; go to DONE.
- DONE:
  - rsp_valid = 1.
  - result and div_by_zero hold stable until rsp_valid && rsp_ready, then go to IDLE.
- Latency: rsp_valid asserts at cycle N+1 for add, sub and div-by-zero; at N+1+WIDTH for mul and div.
- Throughput: minimum one operation per 2 cycles. A request is never accepted in the same cycle a response retires.
- req_ready = (state == IDLE); busy = (state != IDLE).
- Input stability: inputs are sampled only on the accept cycle. Later changes to op_a, op_b or alu_ctrl have no effect on an operation in flight.
- req_valid outside IDLE is ignored; the requester holds the request.
- rsp_ready outside DONE is ignored.
- div_by_zero is cleared on every accepted non-div-by-zero operation.
- Reset mid-operation aborts the operation. The next cycle is in IDLE with reset values, and no response is ever produced for the aborted operation.
- Boundary cases:
  - count wraps only at the MUL/DIV exit, never below 0.
  - mul overflow is silently truncated.
  - div with op_a < op_b returns 0.
  - div of all ones by 1 returns all ones.

Decomposition:
- Package alu_seq_pkg:
  - ALU control code constants ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, shared with the ALU decoder.
  - State enum (IDLE, MUL, DIV, DONE).
  - Count width constant, $clog2(WIDTH).
- One sub-module, alu_iter_unit, is natural:
  - Holds the shift-add/restoring-divide registers and their single-step logic.
  - The FSM, handshake and count live in alu_seq_ctrl.

Test Plan:
- add 5 + 7 accepted at cycle N -> rsp_valid at N+1, result 12, div_by_zero 0; sub 3 - 5 -> 0xFFFFFFFE at N+1 (WIDTH=32).
- mul 0xFFFF * 0xFFFF -> result 0xFFFE0001 at N+33; mul 0x80000000 * 2 -> 0, overflow truncated; busy high through the whole operation.
- div 100 / 7 -> 14 at N+33; div 3 / 9 -> 0; div 0xFFFFFFFF / 1 -> 0xFFFFFFFF.
- div 42 / 0 -> result 0xFFFFFFFF, div_by_zero 1 at N+1; the following add 1 + 1 -> 2 with div_by_zero 0.
- Backpressure: rsp_ready low for 3 cycles after a mul completes -> result and rsp_valid stable, req_ready 0, new req_valid ignored; rsp_ready high -> IDLE next cycle.
- Reset asserted at cycle N+10 of a div -> next cycle state IDLE, req_ready 1, rsp_valid 0; no response for the aborted div; a subsequent add completes normally.
